// File: rtl/i2c_slave_engine.sv
// i2c_slave_engine: I2C register-access slave; byte 2 of a write sets the pointer, reads stream from it.
module i2c_slave_engine #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  input  logic       start_detected,
  input  logic       stop_detected,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK} state_t;
  state_t state_q;
  logic [1:0] scl_sq, sda_sq, sta_sq, sto_sq, ph_q;
  logic scl_prev_q, sta_prev_q, sto_prev_q, rw_q, rd_pend_q, sda_oe_q, wr_en_q, rd_en_q;
  logic [2:0] cnt_q;
  logic [7:0] rx_q, tx_q, reg_addr_q, wr_data_q, byte_d;
  logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;
  assign sda_s    = sda_sq[1];
  assign scl_rise = scl_sq[1] & ~scl_prev_q;
  assign scl_fall = ~scl_sq[1] & scl_prev_q;
  assign start_ev = sta_sq[1] & ~sta_prev_q;
  assign stop_ev  = sto_sq[1] & ~sto_prev_q;
  assign byte_d   = {rx_q[6:0], sda_s};
  assign sda_oe   = sda_oe_q;
  assign reg_addr = reg_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign busy     = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      scl_sq     <= '0;
      sda_sq     <= '0;
      sta_sq     <= '0;
      sto_sq     <= '0;
      scl_prev_q <= 1'b0;
      sta_prev_q <= 1'b0;
      sto_prev_q <= 1'b0;
      ph_q       <= '0;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
    end else begin
      scl_sq     <= {scl_sq[0], scl};
      sda_sq     <= {sda_sq[0], sda};
      sta_sq     <= {sta_sq[0], start_detected};
      sto_sq     <= {sto_sq[0], stop_detected};
      scl_prev_q <= scl_sq[1];
      sta_prev_q <= sta_sq[1];
      sto_prev_q <= sto_sq[1];
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_pend_q  <= rd_en_q;
      if (rd_pend_q) tx_q <= rd_data;
      if (wr_en_q) reg_addr_q <= reg_addr_q + 8'd1;
      if (start_ev) begin
        state_q  <= ADDR;
        cnt_q    <= '0;
        ph_q     <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop_ev) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, REG, WDATA: if (scl_rise) begin
            rx_q  <= byte_d;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ph_q <= '0;
              if (state_q == ADDR) begin
                if (byte_d[7:1] == SLAVE_ADDR) begin
                  rw_q    <= byte_d[0];
                  state_q <= ADDR_ACK;
                end else state_q <= IDLE;
              end else if (state_q == REG) begin
                reg_addr_q <= byte_d;
                state_q    <= REG_ACK;
              end else begin
                wr_data_q <= byte_d;
                wr_en_q   <= 1'b1;
                state_q   <= WDATA_ACK;
              end
            end
          end
          // ph_q: 0 = await fall to drive ACK, 1 = await 9th rise, 2 = await fall to release
          ADDR_ACK, REG_ACK, WDATA_ACK: if (ph_q == 2'd0 && scl_fall) begin
            sda_oe_q <= 1'b1;
            ph_q     <= 2'd1;
          end else if (ph_q == 2'd1 && scl_rise) begin
            ph_q    <= 2'd2;
            rd_en_q <= state_q == ADDR_ACK && rw_q;
          end else if (ph_q == 2'd2 && scl_fall) begin
            ph_q  <= '0;
            cnt_q <= '0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_q  <= RDATA;
              sda_oe_q <= ~tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= state_q == ADDR_ACK ? REG : WDATA;
            end
          end
          RDATA: if (scl_rise) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) ph_q <= 2'd1;
          end else if (scl_fall) begin
            if (ph_q == 2'd1) begin
              sda_oe_q <= 1'b0;
              ph_q     <= '0;
              state_q  <= RDATA_ACK;
            end else begin
              sda_oe_q <= ~tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
            end
          end
          RDATA_ACK: if (scl_rise) begin
            if (!sda_s) begin
              state_q    <= RDATA;
              cnt_q      <= '0;
              rd_en_q    <= 1'b1;
              reg_addr_q <= reg_addr_q + 8'd1;
            end else state_q <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_engine.sv
// tb_i2c_slave_engine: bus-level master model; expected strobes go to a queue checked by a monitor.
module tb_i2c_slave_engine;
  localparam int H = 8;
  logic clk = 1'b0, reset = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic start_detected = 1'b0, stop_detected = 1'b0;
  logic sda_oe, wr_en, rd_en, busy, sda_line;
  logic [7:0] reg_addr, wr_data, rd_data = 8'h00;
  typedef struct {bit wr; logic [7:0] addr; logic [7:0] data;} ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int n_cmp = 0, n_err = 0;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_engine #(.SLAVE_ADDR(7'h48)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda_line),
    .start_detected(start_detected), .stop_detected(stop_detected),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_data(wr_data),
    .wr_en(wr_en), .rd_en(rd_en), .rd_data(rd_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit w, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{wr: w, addr: a, data: d});
  endtask

  always @(negedge clk) begin
    if (!reset && (wr_en || rd_en)) begin
      chk("wr_rd_overlap", {7'd0, wr_en & rd_en}, 8'd0);
      if (exp_q.size() == 0) chk("unexpected_strobe", {6'd0, wr_en, rd_en}, 8'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind", {7'd0, wr_en}, {7'd0, mon_e.wr});
        chk("strobe_addr", reg_addr, mon_e.addr);
        if (mon_e.wr) chk("wr_data", wr_data, mon_e.data);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic seen);
    sda_m = b;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H / 2);
    seen = sda_line;
    wait_clk(H / 2);
    scl = 1'b0;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    sda_m = 1'b0;
    start_detected = 1'b1;
    wait_clk(H);
    scl = 1'b0;
    start_detected = 1'b0;
    wait_clk(H);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    sda_m = 1'b1;
    stop_detected = 1'b1;
    wait_clk(H);
    stop_detected = 1'b0;
    wait_clk(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, s);
    chk(name, {7'd0, s}, {7'd0, ~exp_ack});
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic [7:0] next_rd, input logic m_ack, input string name);
    logic s;
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      got[i] = s;
    end
    rd_data = next_rd;
    bit_x(~m_ack, s);
    chk(name, got, exp);
  endtask

  initial begin
    logic s;
    wait_clk(3);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_sda_oe", {7'd0, sda_oe}, 8'd0);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    reset = 1'b0;
    wait_clk(4);
    // single write 0x10 <= 0xA5
    i2c_start;
    push(1'b1, 8'h10, 8'hA5);
    send_byte(8'h90, 1'b1, "t1_addr_ack");
    chk("t1_busy", {7'd0, busy}, 8'd1);
    send_byte(8'h10, 1'b1, "t1_reg_ack");
    send_byte(8'hA5, 1'b1, "t1_data_ack");
    i2c_stop;
    chk("t1_ptr", reg_addr, 8'h11);
    chk("t1_idle", {7'd0, busy}, 8'd0);
    // foreign address
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_x(8'h92 >> i, s);
    wait_clk(2);
    chk("t2_busy", {7'd0, busy}, 8'd0);
    bit_x(1'b1, s);
    chk("t2_noack", {7'd0, s}, 8'd1);
    i2c_stop;
    // burst write wrapping the pointer
    i2c_start;
    push(1'b1, 8'hFE, 8'h01);
    push(1'b1, 8'hFF, 8'h02);
    push(1'b1, 8'h00, 8'h03);
    send_byte(8'h90, 1'b1, "t3_addr_ack");
    send_byte(8'hFE, 1'b1, "t3_reg_ack");
    send_byte(8'h01, 1'b1, "t3_d0_ack");
    send_byte(8'h02, 1'b1, "t3_d1_ack");
    send_byte(8'h03, 1'b1, "t3_d2_ack");
    i2c_stop;
    chk("t3_ptr", reg_addr, 8'h01);
    // read two bytes from 0xFF, pointer wraps
    i2c_start;
    send_byte(8'h90, 1'b1, "t4_setp_ack");
    send_byte(8'hFF, 1'b1, "t4_reg_ack");
    i2c_stop;
    chk("t4_ptr_set", reg_addr, 8'hFF);
    rd_data = 8'h3C;
    i2c_start;
    push(1'b0, 8'hFF, 8'h00);
    push(1'b0, 8'h00, 8'h00);
    send_byte(8'h91, 1'b1, "t4_addr_ack");
    recv_byte(8'h3C, 8'hC3, 1'b1, "t4_rd0");
    recv_byte(8'hC3, 8'h00, 1'b0, "t4_rd1");
    wait_clk(2);
    chk("t4_idle", {7'd0, busy}, 8'd0);
    chk("t4_sda_oe", {7'd0, sda_oe}, 8'd0);
    i2c_stop;
    chk("t4_ptr_wrap", reg_addr, 8'h00);
    // repeated start after pointer byte, then read
    i2c_start;
    send_byte(8'h90, 1'b1, "t5_addr_ack");
    send_byte(8'h20, 1'b1, "t5_reg_ack");
    rd_data = 8'h5A;
    i2c_start;
    push(1'b0, 8'h20, 8'h00);
    send_byte(8'h91, 1'b1, "t5_raddr_ack");
    recv_byte(8'h5A, 8'h00, 1'b0, "t5_rd");
    i2c_stop;
    chk("t5_ptr", reg_addr, 8'h20);
    // reset while the slave holds the ACK
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_x(8'h90 >> i, s);
    sda_m = 1'b1;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(2);
    chk("t6_oe_held", {7'd0, sda_oe}, 8'd1);
    reset = 1'b1;
    wait_clk(1);
    chk("t6_oe_rst", {7'd0, sda_oe}, 8'd0);
    chk("t6_busy_rst", {7'd0, busy}, 8'd0);
    chk("t6_ptr_rst", reg_addr, 8'h00);
    reset = 1'b0;
    scl = 1'b0;
    wait_clk(H);
    i2c_start;
    push(1'b1, 8'h33, 8'h77);
    send_byte(8'h90, 1'b1, "t6_addr_ack");
    send_byte(8'h33, 1'b1, "t6_reg_ack");
    send_byte(8'h77, 1'b1, "t6_data_ack");
    i2c_stop;
    chk("t6_ptr", reg_addr, 8'h34);
    wait_clk(10);
    chk("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
